// File: rtl/inst_data_arbiter.sv
// rtl/inst_data_arbiter.sv - Arbitrates instruction-fetch and load/store requests onto one bus.
// Keeps at most one bus transaction in flight and routes the handshakes back to its owner.
module inst_data_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic        ownerData;
    logic        lastData;
    logic        latWr;
    logic [1:0]  latSize;
    logic [31:0] latAddr;
    logic [31:0] latWdata;

    logic        grant;
    logic        grantData;
    logic        addrOk;
    logic        dataOk;
    logic        inAddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ownerData <= 1'b0;
            lastData  <= 1'b0;
            latWr     <= 1'b0;
            latSize   <= 2'd0;
            latAddr   <= 32'd0;
            latWdata  <= 32'd0;
        end else begin
            state <= stateNext;
            if (grant) begin
                ownerData <= grantData;
                lastData  <= grantData;
                latWr     <= grantData ? data_wr : 1'b0;
                latSize   <= grantData ? data_size : 2'd2;
                latAddr   <= grantData ? data_addr : inst_addr;
                latWdata  <= grantData ? data_wdata : 32'd0;
            end
        end
    end

    always_comb begin
        // On a tie the fair arbiter hands the bus to whoever did not have it last
        if (FAIR != 0) begin
            grantData = data_req && (!inst_req || !lastData);
        end else begin
            grantData = data_req;
        end
        grant     = 1'b0;
        addrOk    = 1'b0;
        dataOk    = 1'b0;
        stateNext = state;
        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    grant     = 1'b1;
                    stateNext = ADDR;
                end
            end
            ADDR: begin
                addrOk = bus_addr_ok;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        dataOk    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                dataOk = bus_data_ok;
                if (bus_data_ok) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign inAddr       = (state == ADDR);
    assign bus_req      = inAddr;
    assign bus_wr       = inAddr & latWr;
    assign bus_size     = inAddr ? latSize : 2'd0;
    assign bus_addr     = inAddr ? latAddr : 32'd0;
    assign bus_wdata    = inAddr ? latWdata : 32'd0;

    assign inst_addr_ok = addrOk & ~ownerData;
    assign inst_data_ok = dataOk & ~ownerData;
    assign data_addr_ok = addrOk & ownerData;
    assign data_data_ok = dataOk & ownerData;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_inst_data_arbiter.sv
// tb/tb_inst_data_arbiter.sv - Self-checking bench for inst_data_arbiter.
// A transaction-level model predicts every output each cycle; directed cases pin the model.
module tb_inst_data_arbiter;
    localparam int FAIR = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    logic        f0InstAddrOk, f0InstDataOk, f0DataAddrOk, f0DataDataOk;
    logic [31:0] f0InstRdata, f0DataRdata, f0BusAddr, f0BusWdata;
    logic        f0BusReq, f0BusWr;
    logic [1:0]  f0BusSize;

    always #5 clk = ~clk;

    inst_data_arbiter #(.FAIR(FAIR)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    // Fixed-priority instance: both requesters always asking, bus always ready
    inst_data_arbiter #(.FAIR(0)) dutFixed (
        .clk(clk), .rst(rst),
        .inst_req(1'b1), .inst_addr(32'h1000_0000),
        .inst_addr_ok(f0InstAddrOk), .inst_data_ok(f0InstDataOk), .inst_rdata(f0InstRdata),
        .data_req(1'b1), .data_wr(1'b0), .data_size(2'd2),
        .data_addr(32'h2000_0000), .data_wdata(32'd0),
        .data_addr_ok(f0DataAddrOk), .data_data_ok(f0DataDataOk), .data_rdata(f0DataRdata),
        .bus_req(f0BusReq), .bus_wr(f0BusWr), .bus_size(f0BusSize),
        .bus_addr(f0BusAddr), .bus_wdata(f0BusWdata),
        .bus_addr_ok(1'b1), .bus_data_ok(1'b1), .bus_rdata(32'hCAFE_F00D)
    );

    int nChecks = 0;
    int nFails = 0;
    int f0DataGrants = 0;

    int          mPhase;
    bit          mOwnerData, mLastData, mWr;
    bit [1:0]    mSize;
    bit [31:0]   mAddr, mWdata;
    bit          eInstAck, eDataAck;

    task automatic chk1(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mOwnerData = 1'b0;
        mLastData = 1'b0;
        mWr = 1'b0;
        mSize = 2'd0;
        mAddr = 32'd0;
        mWdata = 32'd0;
    endtask

    // mPhase: 0 = no transaction, 1 = address offered, 2 = awaiting data
    task automatic modelCheck();
        bit inAddr, ack, done;
        if (rst) modelReset();
        inAddr = (mPhase == 1);
        ack = inAddr && bus_addr_ok;
        done = (inAddr && bus_addr_ok && bus_data_ok) || (mPhase == 2 && bus_data_ok);
        eInstAck = ack && !mOwnerData;
        eDataAck = ack && mOwnerData;
        chk1("bus_req", bus_req, inAddr);
        chk1("bus_wr", bus_wr, inAddr ? mWr : 1'b0);
        chk32("bus_size", 32'(bus_size), inAddr ? 32'(mSize) : 32'd0);
        chk32("bus_addr", bus_addr, inAddr ? mAddr : 32'd0);
        chk32("bus_wdata", bus_wdata, inAddr ? mWdata : 32'd0);
        chk1("inst_addr_ok", inst_addr_ok, eInstAck);
        chk1("data_addr_ok", data_addr_ok, eDataAck);
        chk1("inst_data_ok", inst_data_ok, done && !mOwnerData);
        chk1("data_data_ok", data_data_ok, done && mOwnerData);
        chk32("inst_rdata", inst_rdata, bus_rdata);
        chk32("data_rdata", data_rdata, bus_rdata);
        chk1("fixed_inst_addr_ok", f0InstAddrOk, 1'b0);
        chk1("fixed_inst_data_ok", f0InstDataOk, 1'b0);
        if (f0DataAddrOk) f0DataGrants++;
    endtask

    task automatic modelStep();
        bit d;
        if (rst) begin
            modelReset();
            return;
        end
        case (mPhase)
            0: if (inst_req || data_req) begin
                if (inst_req && data_req) d = (FAIR != 0) ? !mLastData : 1'b1;
                else d = data_req;
                mOwnerData = d;
                mLastData = d;
                mWr = d ? data_wr : 1'b0;
                mSize = d ? data_size : 2'd2;
                mAddr = d ? data_addr : inst_addr;
                mWdata = d ? data_wdata : 32'd0;
                mPhase = 1;
            end
            1: if (bus_addr_ok) mPhase = bus_data_ok ? 0 : 2;
            2: if (bus_data_ok) mPhase = 0;
            default: mPhase = 0;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        modelCheck();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic quiet();
        inst_req = 1'b0;
        data_req = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    initial begin
        bit glog[$];
        bit [3:0] expOrder;
        modelReset();
        // Reset must clear the outputs before any clock edge
        #1 rst = 1'b1;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        chk1("reset_bus_req", bus_req, 1'b0);
        chk1("reset_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("reset_data_data_ok", data_data_ok, 1'b0);
        chk32("reset_bus_addr", bus_addr, 32'd0);
        quiet();
        tick();
        tick();
        rst = 1'b0;

        // Single fetch
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1 chk1("fetch_idle_bus_req", bus_req, 1'b0);
        tick();
        chk1("fetch_bus_req", bus_req, 1'b1);
        chk32("fetch_bus_addr", bus_addr, 32'hBFC0_0000);
        chk1("fetch_bus_wr", bus_wr, 1'b0);
        chk32("fetch_bus_size", 32'(bus_size), 32'd2);
        tick();
        bus_addr_ok = 1'b1;
        #1 chk1("fetch_inst_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        bus_addr_ok = 1'b0;
        #1 chk1("fetch_wait_data_ok", inst_data_ok, 1'b0);
        tick();
        bus_data_ok = 1'b1;
        bus_rdata = 32'h2408_0001;
        #1;
        chk1("fetch_inst_data_ok", inst_data_ok, 1'b1);
        chk32("fetch_inst_rdata", inst_rdata, 32'h2408_0001);
        chk1("fetch_data_data_ok", data_data_ok, 1'b0);
        tick();
        #1 chk1("fetch_after_data_ok", inst_data_ok, 1'b0);
        quiet();
        tick();

        // Simultaneous requests after reset: data, inst, data, inst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (data_addr_ok) glog.push_back(1'b1);
            if (inst_addr_ok) glog.push_back(1'b0);
            if (k == 1) chk1("same_cycle_data_ok", data_data_ok, 1'b1);
            if (k == 2) chk1("same_cycle_back_to_idle", bus_req, 1'b0);
            tick();
        end
        expOrder = 4'b0101;
        chk32("grant_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk1("grant_order", (i < glog.size()) ? glog[i] : 1'bx, expOrder[i]);
        quiet();
        tick();

        // Store with upstream changes after the latch
        data_req = 1'b1;
        data_wr = 1'b1;
        data_size = 2'd0;
        data_addr = 32'h8000_0003;
        data_wdata = 32'h0000_00AB;
        tick();
        chk1("store_bus_wr", bus_wr, 1'b1);
        chk32("store_bus_size", 32'(bus_size), 32'd0);
        chk32("store_bus_addr", bus_addr, 32'h8000_0003);
        chk32("store_bus_wdata", bus_wdata, 32'h0000_00AB);
        chk1("store_addr_ok_low", data_addr_ok, 1'b0);
        data_addr = 32'h1234_5678;
        data_wdata = 32'h0000_00FF;
        data_wr = 1'b0;
        bus_addr_ok = 1'b1;
        #1;
        chk32("store_addr_held", bus_addr, 32'h8000_0003);
        chk32("store_wdata_held", bus_wdata, 32'h0000_00AB);
        chk1("store_addr_ok_high", data_addr_ok, 1'b1);
        chk1("store_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #1 chk1("store_data_ok", data_data_ok, 1'b1);
        tick();
        #1 chk1("store_idle_data_ok_ignored", data_data_ok, 1'b0);
        tick();
        quiet();

        // Reset during WAIT abandons the transaction
        inst_req = 1'b1;
        inst_addr = 32'h0000_0040;
        bus_addr_ok = 1'b1;
        tick();
        tick();
        inst_req = 1'b0;
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        #1 chk1("rst_wait_bus_req", bus_req, 1'b0);
        bus_data_ok = 1'b1;
        #1 chk1("rst_wait_data_ok", inst_data_ok, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk1("post_rst_data_ok", inst_data_ok, 1'b0);
        chk1("post_rst_bus_req", bus_req, 1'b0);
        tick();
        quiet();
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (inst_req && eInstAck) inst_req = ($urandom % 3 == 0);
            else if (inst_req) begin
                if (!(mPhase != 0 && !mOwnerData) && ($urandom % 8 == 0)) inst_req = 1'b0;
            end else inst_req = ($urandom % 2 == 0);
            if (data_req && eDataAck) data_req = ($urandom % 3 == 0);
            else if (data_req) begin
                if (!(mPhase != 0 && mOwnerData) && ($urandom % 8 == 0)) data_req = 1'b0;
            end else data_req = ($urandom % 2 == 0);
            inst_addr = $urandom;
            data_addr = $urandom;
            data_wdata = $urandom;
            data_wr = 1'($urandom);
            data_size = 2'($urandom_range(0, 2));
            bus_addr_ok = 1'($urandom);
            bus_data_ok = 1'($urandom);
            bus_rdata = $urandom;
            rst = ($urandom % 50 == 0);
            tick();
        end
        rst = 1'b0;
        quiet();
        tick();

        chk1("fixed_priority_data_granted", f0DataGrants > 100, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/inst_data_arbiter.md
INST_DATA_ARBITER -- requirements
Module: inst_data_arbiter

Interface
REQ-001 The module SHALL have parameter FAIR, default 1, where 1 selects round-robin and 0 selects fixed data-over-instruction priority.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port inst_req, input, 1: instruction-fetch request, held until inst_addr_ok.
REQ-005 The module SHALL have port inst_addr, input, 32: fetch address.
REQ-006 The module SHALL have port inst_addr_ok, output, 1: fetch address accepted.
REQ-007 The module SHALL have port inst_data_ok, output, 1: fetch data valid.
REQ-008 The module SHALL have port inst_rdata, output, 32: fetch read data.
REQ-009 The module SHALL have port data_req, input, 1: load/store request, held until data_addr_ok.
REQ-010 The module SHALL have ports data_wr (input, 1, write flag), data_size (input, 2, 0=byte/1=half/2=word), data_addr (input, 32), and data_wdata (input, 32).
REQ-011 The module SHALL have ports data_addr_ok (output, 1), data_data_ok (output, 1), and data_rdata (output, 32).
REQ-012 The module SHALL have bus-side ports bus_req, bus_wr, bus_size[1:0], bus_addr[31:0], and bus_wdata[31:0] (outputs), plus bus_addr_ok, bus_data_ok, and bus_rdata[31:0] (inputs).

Function
REQ-013 The module SHALL implement an FSM with states IDLE, ADDR, and WAIT, and SHALL allow at most one outstanding bus transaction.
REQ-014 In IDLE with any request pending, the module SHALL grant one requester, latch its wr/size/addr/wdata (inst: wr=0, size=2, wdata=0), record the owner, and go to ADDR on the next edge.
REQ-015 Grant rule:
- FAIR=0: data wins whenever data_req=1.
- FAIR=1: if both are pending, the requester not granted last wins; the last-granted flag resets to inst, so data wins the first tie.
REQ-016 In ADDR, bus_req SHALL be 1 and bus_wr/bus_size/bus_addr/bus_wdata SHALL carry the latched values; in IDLE and WAIT, bus_req SHALL be 0.
REQ-017 In ADDR, the owner's addr_ok output SHALL equal bus_addr_ok combinationally; the non-owner's addr_ok SHALL be 0 in all states.
REQ-018 ADDR with bus_addr_ok=1 and bus_data_ok=0 SHALL go to WAIT; ADDR with both 1 SHALL complete in that cycle and go to IDLE.
REQ-019 In WAIT, the owner's data_ok output SHALL equal bus_data_ok combinationally; on bus_data_ok=1 the FSM SHALL go to IDLE.
REQ-020 inst_rdata and data_rdata SHALL both equal bus_rdata at all times; only data_ok qualifies them.
REQ-021 bus_data_ok asserted in IDLE, or in ADDR before bus_addr_ok, SHALL be ignored: no data_ok output and no state change.
REQ-022 A new grant SHALL NOT occur in the cycle a transaction completes; back-to-back transactions SHALL be separated by at least one IDLE cycle, so minimum occupancy is 2 cycles (IDLE->ADDR with same-cycle addr_ok/data_ok).
REQ-023 Requests that drop before grant SHALL cause no bus activity; upstream input changes after the latch in IDLE SHALL NOT alter bus_* until the next grant.

Reset
REQ-024 While rst=1 the FSM SHALL be IDLE, owner=inst, and last-granted=inst, and all outputs except rdata SHALL be 0, independent of clk.
REQ-025 Reset asserted in ADDR or WAIT SHALL abandon the transaction; any later bus_data_ok SHALL be ignored under REQ-021.

Verification
REQ-026 Single fetch: inst_req=1, inst_addr=0xBFC00000; bus addr_ok 1 cycle after bus_req, data_ok 2 cycles later with rdata=0x24080001 -> bus_addr=0xBFC00000, bus_wr=0, bus_size=2, one inst_data_ok pulse with inst_rdata=0x24080001, data_data_ok stays 0.
REQ-027 Simultaneous requests, FAIR=1: inst_req and data_req held with 4 back-to-back transactions -> grant order data, inst, data, inst; FAIR=0 with data_req held -> inst never granted.
REQ-028 Store: data_wr=1, size=0, addr=0x80000003, wdata=0x000000AB -> bus sees those exact values; data_addr_ok mirrors bus_addr_ok; data_data_ok pulses once.
REQ-029 Same-cycle addr_ok and data_ok in ADDR -> FSM returns to IDLE next edge; owner gets addr_ok and data_ok in the same cycle.
REQ-030 rst pulsed during WAIT, then bus_data_ok=1 -> no data_ok output, bus_req=0, FSM in IDLE.
